// File: rtl/i2c_txn_sequencer.sv
// Transaction-level sequencer for the byte-level I2C master: turns one request into
// START+addr / WRITE / READ / STOP commands, streams data bytes and reports status.
`timescale 1ns/1ps
module i2c_txn_sequencer #(
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             cpld_clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic             req_rnw,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic             err_timeout,
  output logic [LEN_W-1:0] xfer_cnt,
  output logic [3:0]       cmd,
  output logic [7:0]       cmd_data,
  output logic             cmd_rd_nack,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  input  logic             eng_done,
  input  logic             eng_ack,
  input  logic [7:0]       eng_rdata
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_W, S_WFETCH, S_WR, S_WR_W,
    S_RD, S_RD_W, S_STOP, S_STOP_W, S_FIN
  } state_t;

  state_t           state, state_nxt;
  logic [6:0]       addr_q;
  logic             rnw_q;
  logic [LEN_W-1:0] rem;
  logic [7:0]       wbyte_q;
  logic [TMO_W-1:0] tmo_q;
  logic             in_wait;
  logic             tmo_hit;

  assign in_wait = (state == S_ADDR_W) || (state == S_WR_W) ||
                   (state == S_RD_W)   || (state == S_STOP_W);
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    cmd         = 4'b0000;
    cmd_data    = 8'h00;
    cmd_rd_nack = 1'b0;
    cmd_valid   = 1'b0;
    done        = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        cmd_valid = 1'b1;
        cmd       = 4'b1100;
        cmd_data  = {addr_q, rnw_q};
        if (cmd_ready) state_nxt = S_ADDR_W;
      end
      S_ADDR_W: begin
        if (eng_done) begin
          if (!eng_ack || rem == '0) state_nxt = S_STOP;
          else if (rnw_q)            state_nxt = S_RD;
          else                       state_nxt = S_WFETCH;
        end else if (tmo_hit) begin
          state_nxt = S_FIN;
        end
      end
      S_WFETCH: begin
        if (wr_valid) begin
          wr_ready  = 1'b1;
          state_nxt = S_WR;
        end
      end
      S_WR: begin
        cmd_valid = 1'b1;
        cmd       = 4'b0100;
        cmd_data  = wbyte_q;
        if (cmd_ready) state_nxt = S_WR_W;
      end
      S_WR_W: begin
        // A NACKed byte ends the transfer; rem==1 means this was the last byte.
        if (eng_done)     state_nxt = (eng_ack && rem != LEN_W'(1)) ? S_WFETCH : S_STOP;
        else if (tmo_hit) state_nxt = S_FIN;
      end
      S_RD: begin
        cmd_valid   = 1'b1;
        cmd         = 4'b0010;
        cmd_rd_nack = (rem == LEN_W'(1));
        if (cmd_ready) state_nxt = S_RD_W;
      end
      S_RD_W: begin
        if (eng_done)     state_nxt = (rem == LEN_W'(1)) ? S_STOP : S_RD;
        else if (tmo_hit) state_nxt = S_FIN;
      end
      S_STOP: begin
        cmd_valid = 1'b1;
        cmd       = 4'b0001;
        if (cmd_ready) state_nxt = S_STOP_W;
      end
      S_STOP_W: begin
        if (eng_done || tmo_hit) state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge cpld_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rem         <= '0;
      xfer_cnt    <= '0;
      nack        <= 1'b0;
      err_timeout <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= 8'h00;
      tmo_q       <= '0;
    end else begin
      state    <= state_nxt;
      rd_valid <= 1'b0;
      if (state == S_IDLE && req_valid) begin
        rem         <= req_len;
        xfer_cnt    <= '0;
        nack        <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (cmd_valid && cmd_ready)      tmo_q <= '0;
      else if (in_wait && !eng_done)   tmo_q <= tmo_q + TMO_W'(1);
      if (in_wait && !eng_done && tmo_hit) err_timeout <= 1'b1;
      if (eng_done) begin
        case (state)
          S_ADDR_W: if (!eng_ack) nack <= 1'b1;
          S_WR_W: begin
            if (eng_ack) begin
              xfer_cnt <= xfer_cnt + LEN_W'(1);
              rem      <= rem - LEN_W'(1);
            end else begin
              nack <= 1'b1;
            end
          end
          S_RD_W: begin
            rd_data  <= eng_rdata;
            rd_valid <= 1'b1;
            xfer_cnt <= xfer_cnt + LEN_W'(1);
            rem      <= rem - LEN_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Request fields and the write byte are pure data; no reset needed.
  always_ff @(posedge cpld_clk) begin
    if (state == S_IDLE && req_valid) begin
      addr_q <= req_addr;
      rnw_q  <= req_rnw;
    end
    if (wr_ready) wbyte_q <= wr_data;
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Randomized bench for i2c_txn_sequencer: a transaction-level model predicts the command
// stream, data bytes and completion status; a negedge process compares every cycle.
`timescale 1ns/1ps
module tb_i2c_txn_sequencer;
  localparam int LEN_W = 4;
  localparam int TMO   = 16;

  logic             cpld_clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_rnw;
  logic [6:0]       req_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       wr_data;
  logic             wr_valid, wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid, busy, done, nack, err_timeout;
  logic [LEN_W-1:0] xfer_cnt;
  logic [3:0]       cmd;
  logic [7:0]       cmd_data;
  logic             cmd_rd_nack, cmd_valid, cmd_ready;
  logic             eng_done, eng_ack;
  logic [7:0]       eng_rdata;

  always #5 cpld_clk = ~cpld_clk;

  i2c_txn_sequencer #(.LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
    .cpld_clk(cpld_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rnw(req_rnw), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .nack(nack), .err_timeout(err_timeout), .xfer_cnt(xfer_cnt),
    .cmd(cmd), .cmd_data(cmd_data), .cmd_rd_nack(cmd_rd_nack),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .eng_done(eng_done), .eng_ack(eng_ack), .eng_rdata(eng_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Transaction plan: command index 0 = address, k = data byte k-1, last = STOP.
  logic [6:0] p_addr;
  logic       p_rnw;
  int         p_len;
  bit         p_ack [0:16];
  logic [7:0] p_rdata [0:15];
  logic [7:0] p_wbytes [0:15];
  int         p_stall;
  int         p_late;

  typedef struct {
    logic [3:0] c;
    logic [7:0] d;
    bit         chk_d;
    bit         is_rd;
    bit         rdn;
  } exp_t;

  exp_t       exp_cmd [$];
  logic [7:0] exp_rd [$];
  int         exp_wr;
  bit         exp_nack, exp_err;
  int         exp_xfer;
  bit         expect_done;

  logic [11:0] cmd_log [$];
  logic [7:0]  rd_log [$];
  logic [7:0]  rdn_bits;
  int          wr_act;
  bit          done_seen;
  bit          last_nack, last_err;
  int          last_xfer;
  bit          hs_cmd, hs_wr;

  task automatic set_plan(input logic [6:0] a, input logic r, input int n);
    p_addr = a; p_rnw = r; p_len = n; p_stall = -1; p_late = -1;
    for (int k = 0; k < 17; k++) p_ack[k] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      p_rdata[k]  = 8'($urandom);
      p_wbytes[k] = 8'($urandom);
    end
  endtask

  // What the transaction must look like, walked through at byte level.
  task automatic build_model();
    exp_cmd.delete(); exp_rd.delete();
    exp_wr = 0; exp_nack = 0; exp_err = 0; exp_xfer = 0;
    exp_cmd.push_back('{4'hC, {p_addr, p_rnw}, 1'b1, 1'b0, 1'b0});
    if (p_stall == 0) begin exp_err = 1; return; end
    if (!p_ack[0]) exp_nack = 1;
    else begin
      for (int i = 0; i < p_len; i++) begin
        if (p_rnw) begin
          exp_cmd.push_back('{4'h2, 8'h00, 1'b0, 1'b1, (i == p_len - 1)});
          if (p_stall == i + 1) begin exp_err = 1; return; end
          exp_rd.push_back(p_rdata[i]);
          exp_xfer++;
        end else begin
          exp_wr++;
          exp_cmd.push_back('{4'h4, p_wbytes[i], 1'b1, 1'b0, 1'b0});
          if (p_stall == i + 1) begin exp_err = 1; return; end
          if (!p_ack[i + 1]) begin exp_nack = 1; break; end
          exp_xfer++;
        end
      end
    end
    if (p_stall == exp_cmd.size()) exp_err = 1;
    exp_cmd.push_back('{4'h1, 8'h00, 1'b0, 1'b0, 1'b0});
  endtask

  // Compare process.
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          prev_stall = 0;
  logic [12:0] prev_word;
  bit          done_prev = 0;
  bit          held_valid = 0;
  logic [5:0]  held_word;

  always @(negedge cpld_clk) begin
    exp_t e;
    if (reset) begin
      prev_stall = 0; done_prev = 0; hs_cmd = 0; hs_wr = 0;
      held_valid = 1; held_word = '0;
    end else begin
      cyc++;
      chk("busy_vs_idle", busy, !req_ready);
      if (done_prev) chk("ready_after_done", req_ready, 1);
      if (req_ready && held_valid) chk("held_status", {nack, err_timeout, xfer_cnt}, held_word);
      if (prev_stall) begin
        chk("hold_valid", cmd_valid, 1);
        chk("hold_cmd", {cmd, cmd_data, cmd_rd_nack}, prev_word);
      end
      prev_stall = cmd_valid && !cmd_ready;
      prev_word  = {cmd, cmd_data, cmd_rd_nack};
      hs_cmd     = cmd_valid && cmd_ready;
      hs_wr      = wr_ready;
      if (hs_cmd) begin
        acc_cyc = cyc;
        cmd_log.push_back({cmd, (cmd == 4'h4 || cmd == 4'hC) ? cmd_data : 8'h00});
        if (cmd == 4'h2) rdn_bits = {rdn_bits[6:0], cmd_rd_nack};
        chk("cmd_expected", exp_cmd.size() != 0, 1);
        if (exp_cmd.size() != 0) begin
          e = exp_cmd.pop_front();
          chk("cmd_code", cmd, e.c);
          if (e.chk_d) chk("cmd_data", cmd_data, e.d);
          if (e.is_rd) chk("cmd_rd_nack", cmd_rd_nack, e.rdn);
        end
      end
      if (wr_ready) begin
        wr_act++;
        chk("wr_ready_bound", wr_act <= exp_wr, 1);
      end
      if (rd_valid) begin
        rd_log.push_back(rd_data);
        chk("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) chk("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        chk("done_expected", expect_done, 1);
        chk("done_req_ready", req_ready, 0);
        chk("done_nack", nack, exp_nack);
        chk("done_err", err_timeout, exp_err);
        chk("done_xfer", xfer_cnt, exp_xfer);
        chk("done_cmds_left", exp_cmd.size(), 0);
        chk("done_rd_left", exp_rd.size(), 0);
        chk("done_wr_cnt", wr_act, exp_wr);
        if (exp_err) chk("tmo_latency", cyc - acc_cyc, TMO + 1);
        last_nack = nack; last_err = err_timeout; last_xfer = int'(xfer_cnt);
        held_word = {nack, err_timeout, xfer_cnt}; held_valid = 1;
        done_seen = 1; expect_done = 0;
      end
      done_prev = done;
    end
  end

  task automatic idle_inputs();
    req_valid = 0; req_addr = '0; req_rnw = 0; req_len = '0;
    wr_valid = 0; wr_data = '0; cmd_ready = 0;
    eng_done = 0; eng_ack = 0; eng_rdata = '0;
  endtask

  // Drives one request and plays the engine; rst_after>=0 resets that many cycles after a hang.
  task automatic run_txn(input int rst_after);
    int  budget, dly, pidx, wr_idx, cmd_idx, rcount;
    bit  pend, hung, aborted;
    build_model();
    cmd_log.delete(); rd_log.delete(); rdn_bits = '0; wr_act = 0;
    done_seen = 0; expect_done = 1;
    cmd_idx = 0; wr_idx = 0; pend = 0; hung = 0; aborted = 0; dly = 0; pidx = 0;
    rcount = rst_after;
    @(posedge cpld_clk); #1;
    req_valid = 1; req_addr = p_addr; req_rnw = p_rnw; req_len = LEN_W'(p_len);
    budget = 0;
    while (!done_seen && budget < 800) begin
      @(posedge cpld_clk); #1;
      budget++;
      req_valid = 0; req_addr = 7'($urandom); req_rnw = 1'($urandom); req_len = LEN_W'($urandom);
      if (hs_cmd) begin
        if (cmd_idx == p_stall) hung = 1;
        else begin
          pend = 1; pidx = cmd_idx;
          dly = (cmd_idx == p_late) ? TMO - 1 : $urandom_range(0, 3);
        end
        cmd_idx++;
      end
      if (hs_wr) wr_idx++;
      if (hung && rcount >= 0) begin
        if (rcount == 0) begin
          idle_inputs();
          reset = 1; expect_done = 0; exp_cmd.delete(); exp_rd.delete();
          @(posedge cpld_clk); #1;
          reset = 0; cmd_ready = 1;
          @(negedge cpld_clk);
          chk("rst_cmd_valid", cmd_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_req_ready", req_ready, 1);
          chk("rst_done", done, 0);
          repeat (8) @(posedge cpld_clk);
          #1 cmd_ready = 0;
          aborted = 1;
          break;
        end
        rcount--;
      end
      eng_done = 0; eng_ack = 1'($urandom); eng_rdata = 8'($urandom);
      if (pend) begin
        if (dly == 0) begin
          eng_done = 1; eng_ack = p_ack[pidx];
          if (pidx > 0) eng_rdata = p_rdata[pidx - 1];
          pend = 0;
        end else dly--;
      end else if (!hung && $urandom_range(0, 7) == 0) begin
        eng_done = 1;
      end
      cmd_ready = 1'($urandom);
      wr_valid  = 1'($urandom);
      wr_data   = (wr_valid && wr_idx < 16) ? p_wbytes[wr_idx] : 8'($urandom);
    end
    if (!aborted && !done_seen) chk("txn_finished", done_seen, 1);
    idle_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    idle_inputs();
    repeat (3) @(posedge cpld_clk);
    @(negedge cpld_clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_cmd_valid", cmd_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_status", {nack, err_timeout, xfer_cnt}, 0);
    @(posedge cpld_clk); #1 reset = 0;

    // Write 0x50, A5 3C, all ACK.
    set_plan(7'h50, 0, 2); p_wbytes[0] = 8'hA5; p_wbytes[1] = 8'h3C;
    run_txn(-1);
    chk("w2_len", cmd_log.size(), 4);
    chk("w2_c0", cmd_log[0], 12'hCA0);
    chk("w2_c1", cmd_log[1], 12'h4A5);
    chk("w2_c2", cmd_log[2], 12'h43C);
    chk("w2_c3", cmd_log[3], 12'h100);
    chk("w2_status", {last_err, last_nack, 4'(last_xfer)}, 6'h02);

    // Read 0x50, 3 bytes.
    set_plan(7'h50, 1, 3); p_rdata[0] = 8'h11; p_rdata[1] = 8'h22; p_rdata[2] = 8'h33;
    run_txn(-1);
    chk("r3_len", cmd_log.size(), 5);
    chk("r3_c0", cmd_log[0], 12'hCA1);
    chk("r3_c1", cmd_log[1], 12'h200);
    chk("r3_c4", cmd_log[4], 12'h100);
    chk("r3_rdnack", rdn_bits, 8'b001);
    chk("r3_nbytes", rd_log.size(), 3);
    chk("r3_b0", rd_log[0], 8'h11);
    chk("r3_b1", rd_log[1], 8'h22);
    chk("r3_b2", rd_log[2], 8'h33);
    chk("r3_xfer", last_xfer, 3);

    // Address NACK on write len 4.
    set_plan(7'h50, 0, 4); p_ack[0] = 0;
    run_txn(-1);
    chk("an_len", cmd_log.size(), 2);
    chk("an_stop", cmd_log[1], 12'h100);
    chk("an_wr", wr_act, 0);
    chk("an_status", {last_err, last_nack, 4'(last_xfer)}, 6'h10);

    // Write len 3, byte 2 NACKed.
    set_plan(7'h50, 0, 3); p_ack[2] = 0;
    run_txn(-1);
    chk("bn_len", cmd_log.size(), 4);
    chk("bn_stop", cmd_log[3], 12'h100);
    chk("bn_wr", wr_act, 2);
    chk("bn_status", {last_err, last_nack, 4'(last_xfer)}, 6'h11);

    // Engine hangs after the address command.
    set_plan(7'h50, 0, 2); p_stall = 0;
    run_txn(-1);
    chk("to_len", cmd_log.size(), 1);
    chk("to_status", {last_err, last_nack, 4'(last_xfer)}, 6'h20);
    @(negedge cpld_clk);
    chk("to_ready_next", req_ready, 1);

    // Address-only probe.
    set_plan(7'h50, 0, 0);
    run_txn(-1);
    chk("pr_len", cmd_log.size(), 2);
    chk("pr_c0", cmd_log[0], 12'hCA0);
    chk("pr_c1", cmd_log[1], 12'h100);
    chk("pr_xfer", last_xfer, 0);

    // eng_done arriving on the last timeout cycle still completes normally.
    set_plan(7'h2A, 0, 1); p_late = 1;
    run_txn(-1);
    chk("late_status", {last_err, last_nack, 4'(last_xfer)}, 6'h01);

    // Reset while waiting for a read byte.
    set_plan(7'h50, 1, 3); p_stall = 1;
    run_txn(2);

    for (int t = 0; t < 40; t++) begin
      set_plan(7'($urandom), 1'($urandom), $urandom_range(0, 6));
      for (int k = 0; k < 17; k++) p_ack[k] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) p_stall = $urandom_range(0, p_len + 1);
      if ($urandom_range(0, 5) == 0) p_late  = $urandom_range(0, p_len + 1);
      repeat ($urandom_range(0, 3)) @(posedge cpld_clk);
      run_txn(-1);
    end

    repeat (3) @(posedge cpld_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
